// File: rtl/execute_stage.sv
// execute_stage: ALU/jump execute stage with one-entry result forwarding and post-jump squash.
module execute_stage (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STAGE3IN,
  input  logic [15:0] IRIN,
  input  logic [15:0] PCIN,
  input  logic [15:0] DATAIN1,
  input  logic [15:0] DATAIN2,
  input  logic [15:0] DATAIN3,
  input  logic        STAGE4READY,
  output logic        STALL,
  output logic        VALIDOUT,
  output logic [15:0] IROUT,
  output logic [15:0] PCOUT,
  output logic [15:0] RESULT,
  output logic [3:0]  WREG,
  output logic        WEN,
  output logic        JUMPEN,
  output logic [15:0] JUMPADDR
);
  localparam logic [3:0] ADD = 4'h1, OR = 4'h2, AND = 4'h3, SUB = 4'h4, SLT = 4'h5, ADDI = 4'h6, JUMP = 4'h7;
  logic        fwd_valid, squash, accept, is_alu, is_addi, taken, wen_n;
  logic [3:0]  fwd_reg, op, wreg_n;
  logic [15:0] fwd_data, opa, opb, opr, res;
  always_comb begin
    op      = IRIN[15:12];
    accept  = STAGE3IN & STAGE4READY;
    opa     = (fwd_valid && fwd_reg == IRIN[7:4])  ? fwd_data : DATAIN2;
    opb     = (fwd_valid && fwd_reg == IRIN[3:0])  ? fwd_data : DATAIN3;
    opr     = (fwd_valid && fwd_reg == IRIN[11:8]) ? fwd_data : DATAIN3;
    is_alu  = op == ADD || op == OR || op == AND || op == SUB || op == SLT;
    is_addi = op == ADDI;
    res     = op == ADD ? opa + opb :
              op == SUB ? opa - opb :
              op == AND ? opa & opb :
              op == OR  ? opa | opb :
              op == SLT ? {15'd0, $signed(opa) < $signed(opb)} :
              is_addi   ? opr + DATAIN2 : 16'd0;
    wreg_n  = is_alu ? DATAIN1[3:0] : is_addi ? IRIN[11:8] : 4'd0;
    wen_n   = ~squash & (is_alu | is_addi) & (wreg_n != 4'd0);
    taken   = ~squash & (op == JUMP);
  end
  assign STALL = STAGE3IN & ~STAGE4READY;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      VALIDOUT  <= 1'b0;
      WEN       <= 1'b0;
      JUMPEN    <= 1'b0;
      RESULT    <= 16'h0000;
      IROUT     <= 16'h0000;
      PCOUT     <= 16'h0000;
      JUMPADDR  <= 16'h0000;
      WREG      <= 4'h0;
      fwd_valid <= 1'b0;
      fwd_reg   <= 4'h0;
      fwd_data  <= 16'h0000;
      squash    <= 1'b0;
    end else if (accept) begin
      VALIDOUT  <= ~squash;
      WEN       <= wen_n;
      JUMPEN    <= taken;
      IROUT     <= IRIN;
      PCOUT     <= PCIN;
      RESULT    <= res;
      WREG      <= wreg_n;
      fwd_valid <= wen_n;
      squash    <= taken;
      if (taken) JUMPADDR <= {8'h00, DATAIN1[7:0]};
      if (wen_n) begin
        fwd_reg  <= wreg_n;
        fwd_data <= res;
      end
    end else begin
      JUMPEN <= 1'b0;
      if (!STAGE3IN) begin
        VALIDOUT <= 1'b0;
        WEN      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and randomized checks of execute_stage against a behavioural model.
module tb_execute_stage;
  localparam logic [3:0] ADD = 4'h1, OR = 4'h2, AND = 4'h3, SUB = 4'h4, SLT = 4'h5, ADDI = 4'h6, JUMP = 4'h7;
  logic clk = 1'b0, rst_n = 1'b0, s3in = 1'b0, rdy = 1'b1;
  logic [15:0] ir = '0, pc = '0, d1 = '0, d2 = '0, d3 = '0;
  logic stall, validout, wen, jumpen;
  logic [15:0] irout, pcout, result, jumpaddr;
  logic [3:0] wreg;
  int n_pass = 0, n_total = 0;
  logic m_fv, m_sq;
  logic [3:0] m_fr;
  logic [15:0] m_fd;
  logic e_valid, e_wen, e_jen;
  logic [15:0] e_ir, e_pc, e_res, e_jaddr;
  logic [3:0] e_wreg;

  execute_stage dut (
    .CLK(clk), .RST_N(rst_n), .STAGE3IN(s3in), .IRIN(ir), .PCIN(pc),
    .DATAIN1(d1), .DATAIN2(d2), .DATAIN3(d3), .STAGE4READY(rdy),
    .STALL(stall), .VALIDOUT(validout), .IROUT(irout), .PCOUT(pcout),
    .RESULT(result), .WREG(wreg), .WEN(wen), .JUMPEN(jumpen), .JUMPADDR(jumpaddr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pick(input logic [3:0] r, input logic [15:0] dflt);
    return (m_fv && m_fr == r) ? m_fd : dflt;
  endfunction

  task automatic model_reset();
    {m_fv, m_sq, m_fr, m_fd} = '0;
    {e_valid, e_wen, e_jen, e_ir, e_pc, e_res, e_jaddr, e_wreg} = '0;
  endtask

  // Architectural effect of one clock edge, from the current inputs.
  task automatic model_clock();
    logic [15:0] a, b, r;
    logic [3:0] dst;
    logic writes, jmp, w;
    if (s3in && rdy) begin
      a = pick(ir[7:4], d2);
      b = pick(ir[3:0], d3);
      r = 16'd0; dst = 4'd0; writes = 1'b0; jmp = 1'b0;
      case (ir[15:12])
        ADD:  begin r = 16'(a + b); dst = d1[3:0]; writes = 1'b1; end
        SUB:  begin r = 16'(a - b); dst = d1[3:0]; writes = 1'b1; end
        AND:  begin r = a & b; dst = d1[3:0]; writes = 1'b1; end
        OR:   begin r = a | b; dst = d1[3:0]; writes = 1'b1; end
        SLT:  begin r = (int'($signed(a)) < int'($signed(b))) ? 16'd1 : 16'd0; dst = d1[3:0]; writes = 1'b1; end
        ADDI: begin r = 16'(pick(ir[11:8], d3) + d2); dst = ir[11:8]; writes = 1'b1; end
        JUMP: jmp = 1'b1;
        default: ;
      endcase
      w = writes && dst != 0 && !m_sq;
      e_valid = !m_sq; e_wen = w; e_jen = jmp && !m_sq;
      e_ir = ir; e_pc = pc; e_res = r; e_wreg = dst;
      if (e_jen) e_jaddr = {8'h00, d1[7:0]};
      m_fv = w;
      if (w) begin m_fr = dst; m_fd = r; end
      m_sq = e_jen;
    end else begin
      e_jen = 1'b0;
      if (!s3in) begin e_valid = 1'b0; e_wen = 1'b0; end
    end
  endtask

  task automatic step(input logic v, input logic [15:0] i, input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] a3, input logic r);
    @(negedge clk);
    s3in = v; ir = i; pc = pc + 16'd1; d1 = a1; d2 = a2; d3 = a3; rdy = r;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (validout !== 1'b0) $display("FAIL reset_valid got %b want 0", validout); else n_pass++;
    n_total++; if (wen !== 1'b0) $display("FAIL reset_wen got %b want 0", wen); else n_pass++;
    n_total++; if (jumpen !== 1'b0) $display("FAIL reset_jumpen got %b want 0", jumpen); else n_pass++;
    n_total++; if ({result, irout, pcout, jumpaddr, wreg} !== 68'h0) $display("FAIL reset_regs got %h %h %h %h %h want zero", result, irout, pcout, jumpaddr, wreg); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    step(1, {ADD, 4'h1, 4'h2, 4'h3}, 16'd1, 16'd5, 16'd7, 1);
    n_total++; if (result !== 16'd12) $display("FAIL add_result got %h want %h", result, 16'd12); else n_pass++;
    n_total++; if ({validout, wen, wreg} !== {1'b1, 1'b1, 4'd1}) $display("FAIL add_ctl got %b%b%h want 111", validout, wen, wreg); else n_pass++;
    n_total++; if (irout !== ir || pcout !== pc) $display("FAIL add_irpc got %h %h want %h %h", irout, pcout, ir, pc); else n_pass++;
  endtask

  task automatic test_forward();
    step(1, {ADD, 4'h4, 4'h2, 4'h3}, 16'd4, 16'd4, 16'd5, 1);
    n_total++; if (result !== 16'd9) $display("FAIL fwd_src got %h want %h", result, 16'd9); else n_pass++;
    step(1, {SUB, 4'h5, 4'h4, 4'h3}, 16'd5, 16'd0, 16'd2, 1);
    n_total++; if (result !== 16'd7) $display("FAIL fwd_use got %h want %h", result, 16'd7); else n_pass++;
    step(1, {ADD, 4'h0, 4'h2, 4'h3}, 16'd0, 16'd4, 16'd5, 1);
    n_total++; if (wen !== 1'b0 || validout !== 1'b1) $display("FAIL r0_wen got wen=%b valid=%b want 0 1", wen, validout); else n_pass++;
    step(1, {SUB, 4'h5, 4'h0, 4'h3}, 16'd5, 16'd0, 16'd2, 1);
    n_total++; if (result !== 16'hFFFE) $display("FAIL r0_nofwd got %h want %h", result, 16'hFFFE); else n_pass++;
  endtask

  task automatic test_slt();
    step(1, {SLT, 4'h1, 4'h2, 4'h3}, 16'd1, 16'hFFFF, 16'h0001, 1);
    n_total++; if (result !== 16'd1) $display("FAIL slt_neg got %h want 1", result); else n_pass++;
    step(1, {SLT, 4'h1, 4'h2, 4'h3}, 16'd1, 16'h0001, 16'hFFFF, 1);
    n_total++; if (result !== 16'd0) $display("FAIL slt_swap got %h want 0", result); else n_pass++;
    step(1, {SUB, 4'h1, 4'h2, 4'h3}, 16'd1, 16'h0000, 16'h0001, 1);
    n_total++; if (result !== 16'hFFFF) $display("FAIL sub_wrap got %h want %h", result, 16'hFFFF); else n_pass++;
  endtask

  task automatic test_jump();
    step(1, {JUMP, 4'h0, 8'h3C}, 16'h003C, 16'd0, 16'd0, 1);
    n_total++; if (jumpen !== 1'b1 || jumpaddr !== 16'h003C) $display("FAIL jump_pulse got %b %h want 1 003c", jumpen, jumpaddr); else n_pass++;
    n_total++; if (wen !== 1'b0 || result !== 16'h0) $display("FAIL jump_nowrite got %b %h want 0 0000", wen, result); else n_pass++;
    step(1, {ADD, 4'h1, 4'h2, 4'h3}, 16'd1, 16'd3, 16'd4, 1);
    n_total++; if ({validout, wen, jumpen} !== 3'b000) $display("FAIL squash got %b%b%b want 000", validout, wen, jumpen); else n_pass++;
    n_total++; if (irout !== {ADD, 4'h1, 4'h2, 4'h3}) $display("FAIL squash_ir got %h want %h", irout, {ADD, 4'h1, 4'h2, 4'h3}); else n_pass++;
    step(1, {ADD, 4'h2, 4'h2, 4'h3}, 16'd2, 16'd10, 16'd20, 1);
    n_total++; if ({validout, wen} !== 2'b11 || result !== 16'd30) $display("FAIL post_squash got %b%b %h want 11 001e", validout, wen, result); else n_pass++;
    step(1, {JUMP, 4'h0, 8'h55}, 16'h0055, 16'd0, 16'd0, 1);
    step(1, {ADD, 4'h2, 4'h2, 4'h3}, 16'd2, 16'd10, 16'd20, 0);
    n_total++; if (jumpen !== 1'b0 || validout !== 1'b1) $display("FAIL jump_stall got jen=%b valid=%b want 0 1", jumpen, validout); else n_pass++;
    step(1, {ADD, 4'h2, 4'h2, 4'h3}, 16'd2, 16'd10, 16'd20, 1);
    n_total++; if (validout !== 1'b0) $display("FAIL squash_after_stall got %b want 0", validout); else n_pass++;
  endtask

  task automatic test_stall();
    logic [15:0] held;
    step(1, {ADD, 4'h1, 4'h2, 4'h3}, 16'd1, 16'd40, 16'd2, 1);
    held = e_res;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s3in = 1; ir = {ADDI, 4'h6, 8'h05}; d1 = 16'd0; d2 = 16'd5; d3 = 16'd100; rdy = 0;
      #1;
      n_total++; if (stall !== 1'b1) $display("FAIL stall_flag got %b want 1", stall); else n_pass++;
      @(posedge clk);
      model_clock();
      #1;
      n_total++; if (result !== held || wreg !== 4'd1 || wen !== 1'b1) $display("FAIL stall_hold got %h %h %b want %h 1 1", result, wreg, wen, held); else n_pass++;
    end
    step(1, {ADDI, 4'h6, 8'h05}, 16'd0, 16'd5, 16'd100, 1);
    n_total++; if (result !== 16'd105 || wreg !== 4'd6 || wen !== 1'b1) $display("FAIL addi got %h %h %b want 0069 6 1", result, wreg, wen); else n_pass++;
    step(0, {ADDI, 4'h6, 8'h05}, 16'd0, 16'd5, 16'd100, 1);
    n_total++; if (validout !== 1'b0 || wen !== 1'b0 || result !== 16'd105) $display("FAIL idle got %b %b %h want 0 0 0069", validout, wen, result); else n_pass++;
  endtask

  task automatic test_async_reset();
    step(1, {JUMP, 4'h0, 8'h21}, 16'h0021, 16'd0, 16'd0, 1);
    @(negedge clk);
    s3in = 1; ir = {ADD, 4'h1, 4'h2, 4'h3}; d1 = 16'd1; d2 = 16'd6; d3 = 16'd7; rdy = 0;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if ({validout, wen, jumpen} !== 3'b000) $display("FAIL async_ctl got %b%b%b want 000", validout, wen, jumpen); else n_pass++;
    n_total++; if ({result, irout, pcout, jumpaddr, wreg} !== 68'h0) $display("FAIL async_regs got %h %h %h %h %h want zero", result, irout, pcout, jumpaddr, wreg); else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, {ADD, 4'h1, 4'h2, 4'h3}, 16'd1, 16'd6, 16'd7, 1);
    n_total++; if ({validout, wen} !== 2'b11 || result !== 16'd13) $display("FAIL after_reset got %b%b %h want 11 000d", validout, wen, result); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] ops [9] = '{4'h0, ADD, OR, AND, SUB, SLT, ADDI, JUMP, 4'hB};
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      s3in = $urandom_range(0, 7) != 0;
      rdy  = $urandom_range(0, 4) != 0;
      ir   = {ops[$urandom_range(0, 8)], 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      pc   = 16'($urandom);
      d1   = {12'($urandom), 4'($urandom_range(0, 3))};
      d2   = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 3));
      d3   = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'hFFFF - 16'($urandom_range(0, 3));
      #1;
      n_total++; if (stall !== (s3in & ~rdy)) $display("FAIL rnd_stall k=%0d got %b want %b", k, stall, s3in & ~rdy); else n_pass++;
      @(posedge clk);
      model_clock();
      #1;
      n_total++; if ({validout, wen, jumpen} !== {e_valid, e_wen, e_jen}) $display("FAIL rnd_ctl k=%0d got %b%b%b want %b%b%b", k, validout, wen, jumpen, e_valid, e_wen, e_jen); else n_pass++;
      n_total++; if (irout !== e_ir || pcout !== e_pc) $display("FAIL rnd_irpc k=%0d got %h %h want %h %h", k, irout, pcout, e_ir, e_pc); else n_pass++;
      if (e_valid) begin
        n_total++; if (result !== e_res || wreg !== e_wreg) $display("FAIL rnd_result k=%0d ir=%h got %h %h want %h %h", k, e_ir, result, wreg, e_res, e_wreg); else n_pass++;
      end
      if (e_jen) begin
        n_total++; if (jumpaddr !== e_jaddr) $display("FAIL rnd_jaddr k=%0d got %h want %h", k, jumpaddr, e_jaddr); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_slt();
    test_jump();
    test_stall();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
